// File: rtl/pattern_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pattern_arbiter
// Description : Two-requester arbiter in front of one shared 4-bit pattern
//               matcher. Each request is decided in IDLE, granted for one
//               cycle (operand captured), and answered one cycle later.
//               Ties go to the requester that did not win last time.
//               Optional post-reset flush phase is enabled by defining
//               PATTERN_ARBITER_FLUSH_EN; without it reset goes to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_arbiter #(
    parameter logic [3:0] PATTERN     = 4'b0101,
    parameter int         INIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] data0,
    input  logic       req1,
    input  logic [3:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       match_valid,
    output logic       match,
    output logic       match_id,
    output logic       busy
);

    localparam logic [1:0] S_FLUSH  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_GRANT  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

`ifdef PATTERN_ARBITER_FLUSH_EN
    localparam logic [1:0] c_reset_state = S_FLUSH;
    localparam logic       c_reset_busy  = 1'b1;
    localparam logic [3:0] c_flush_last  = 4'(INIT_CYCLES - 1);
`else
    localparam logic [1:0] c_reset_state = S_IDLE;
    localparam logic       c_reset_busy  = 1'b0;
`endif

    // Out-of-range flush lengths are rejected at elaboration.
    if (INIT_CYCLES < 1 || INIT_CYCLES > 15) begin : g_init_cycles_check
        $error("pattern_arbiter: INIT_CYCLES must be in 1..15");
    end

    logic [1:0] state_q, state_d;
    logic [3:0] operand_q, operand_d;
    logic       last_winner_q, last_winner_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       match_valid_q, match_valid_d;
    logic       match_q, match_d;
    logic       match_id_q, match_id_d;
    logic       busy_q, busy_d;
`ifdef PATTERN_ARBITER_FLUSH_EN
    logic [3:0] count_q, count_d;
`endif

    // Winner of the IDLE decision: a lone requester wins, a tie goes to the
    // requester that lost last time.
    logic w_pick;
    assign w_pick = (req0 && req1) ? ~last_winner_q : req1;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= c_reset_state;
            operand_q     <= 4'b0000;
            last_winner_q <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            match_id_q    <= 1'b0;
            busy_q        <= c_reset_busy;
`ifdef PATTERN_ARBITER_FLUSH_EN
            count_q       <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            operand_q     <= operand_d;
            last_winner_q <= last_winner_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            match_id_q    <= match_id_d;
            busy_q        <= busy_d;
`ifdef PATTERN_ARBITER_FLUSH_EN
            count_q       <= count_d;
`endif
        end
    end

    // Next-state logic: flush countdown, arbitration, operand capture.
    always_comb begin
        state_d       = state_q;
        operand_d     = operand_q;
        last_winner_d = last_winner_q;
`ifdef PATTERN_ARBITER_FLUSH_EN
        count_d       = count_q;
`endif
        case (state_q)
`ifdef PATTERN_ARBITER_FLUSH_EN
            S_FLUSH: begin
                operand_d = 4'b0000;
                if (count_q == c_flush_last) begin
                    count_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
`endif
            S_IDLE: begin
                if (req0 || req1) begin
                    last_winner_d = w_pick;
                    state_d       = S_GRANT;
                end
            end
            S_GRANT: begin
                operand_d = last_winner_q ? data1 : data0;
                state_d   = S_RESULT;
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: values the outputs take in the state being entered.
    always_comb begin
        gnt0_d        = (state_d == S_GRANT) && !last_winner_d;
        gnt1_d        = (state_d == S_GRANT) &&  last_winner_d;
        match_valid_d = (state_d == S_RESULT);
        match_d       = (state_d == S_RESULT) && (operand_d == PATTERN);
        match_id_d    = (state_d == S_RESULT) && last_winner_q;
        busy_d        = (state_d != S_IDLE);
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign match_valid = match_valid_q;
    assign match       = match_q;
    assign match_id    = match_id_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_arbiter
// Description : Self-checking bench for pattern_arbiter. A schedule-based
//               reference model predicts grants/results per clock edge.
//               Honours PATTERN_ARBITER_FLUSH_EN for the flush length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_arbiter;

    localparam logic [3:0] PAT  = 4'b0101;
    localparam int         INIT = 2;
`ifdef PATTERN_ARBITER_FLUSH_EN
    localparam int FL = INIT;
`else
    localparam int FL = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [3:0] data0 = 4'd0;
    logic [3:0] data1 = 4'd0;
    logic       gnt0, gnt1, match_valid, match, match_id, busy;

    always #5 clk = ~clk;

    pattern_arbiter #(.PATTERN(PAT), .INIT_CYCLES(INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .match_valid(match_valid),
        .match(match), .match_id(match_id), .busy(busy)
    );

    // Reference model: flush countdown plus a schedule of the current op.
    int         flush_left;
    bit         m_last;
    int         edge_n;
    int         op_edge;
    int         next_free;
    bit         op_who;
    logic [5:0] exp_v;      // {gnt0,gnt1,match_valid,match,match_id,busy}
    logic [5:0] rst_v;
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic logic [5:0] obs();
        return {gnt0, gnt1, match_valid, match, match_id, busy};
    endfunction

    task automatic model_reset();
        flush_left = FL;
        m_last     = 1'b1;
        op_edge    = -100;
        next_free  = 0;
        edge_n     = 0;
        exp_v      = {5'b0, (FL > 0)};
    endtask

    // Advance one clock edge and compute what the outputs must be after it.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        exp_v = 6'b0;
        if (flush_left > 0) begin
            flush_left--;
            exp_v[0] = (flush_left > 0);
        end else begin
            if (edge_n == op_edge + 1) begin
                exp_v[3] = 1'b1;
                exp_v[2] = ((op_who ? data1 : data0) == PAT);
                exp_v[1] = op_who;
                exp_v[0] = 1'b1;
            end
            if (edge_n >= next_free && (req0 || req1)) begin
                op_who    = (req0 && req1) ? !m_last : req1;
                m_last    = op_who;
                op_edge   = edge_n;
                next_free = edge_n + 3;
                exp_v[5]  = !op_who;
                exp_v[4]  = op_who;
                exp_v[0]  = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0  = 1'b1;
        #12;
        rst_v = {5'b0, (FL > 0)};
        n_checks++;
        if (obs() !== rst_v) $display("FAIL reset_state: got %b want %b", obs(), rst_v);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < FL + 3; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v) $display("FAIL reset_release[%0d]: got %b want %b", i, obs(), exp_v);
            else n_pass++;
        end
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v) $display("FAIL reset_drain[%0d]: got %b want %b", i, obs(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_match_req0();
        req0  = 1'b1;
        data0 = PAT;
        tick();
        req0 = 1'b0;
        n_checks++;
        if (obs() !== 6'b100001) $display("FAIL match0_grant: got %b want %b", obs(), 6'b100001);
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== 6'b001101) $display("FAIL match0_result: got %b want %b", obs(), 6'b001101);
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== exp_v) $display("FAIL match0_idle: got %b want %b", obs(), exp_v);
        else n_pass++;
    endtask

    task automatic test_mismatch_req1();
        req1  = 1'b1;
        data1 = 4'b0111;
        tick();
        req1 = 1'b0;
        n_checks++;
        if (obs() !== 6'b010001) $display("FAIL mismatch1_grant: got %b want %b", obs(), 6'b010001);
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== 6'b001011) $display("FAIL mismatch1_result: got %b want %b", obs(), 6'b001011);
        else n_pass++;
        tick();
    endtask

    task automatic test_drop();
        // req1 pulses only while busy, so it must be discarded.
        req0 = 1'b1;
        data0 = 4'b1111;
        tick();
        req0 = 1'b0;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            req1 = 1'b0;
            n_checks++;
            if (obs() !== exp_v) $display("FAIL drop[%0d]: got %b want %b", i, obs(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_alternate();
        int order[$];
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data0 = 4'($urandom);
            data1 = 4'($urandom);
            tick();
            n_checks++;
            if (obs() !== exp_v) $display("FAIL alternate[%0d]: got %b want %b", i, obs(), exp_v);
            else n_pass++;
            if (gnt0 === 1'b1) order.push_back(0);
            if (gnt1 === 1'b1) order.push_back(1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_checks++;
        if (order.size() < 4) $display("FAIL alternate_count: got %0d want >=4", order.size());
        else if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1)
            $display("FAIL alternate_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 90; i++) begin
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            data0 = ($urandom_range(0, 2) == 0) ? PAT : 4'($urandom);
            data1 = ($urandom_range(0, 2) == 0) ? PAT : 4'($urandom);
            tick();
            n_checks++;
            if (obs() !== exp_v) $display("FAIL random[%0d]: got %b want %b", i, obs(), exp_v);
            else n_pass++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_abort_reset();
        req1  = 1'b1;
        data1 = PAT;
        tick();
        req1 = 1'b0;
        n_checks++;
        if (obs() !== exp_v || gnt1 !== 1'b1) $display("FAIL abort_grant: got %b want %b", obs(), exp_v);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        rst_v = {5'b0, (FL > 0)};
        n_checks++;
        if (obs() !== rst_v) $display("FAIL abort_async: got %b want %b", obs(), rst_v);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs() !== rst_v) $display("FAIL abort_hold[%0d]: got %b want %b", i, obs(), rst_v);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req0 = 1'b1;
        for (int i = 0; i < FL + 3; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v) $display("FAIL abort_reflush[%0d]: got %b want %b", i, obs(), exp_v);
            else n_pass++;
        end
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_match_req0();
        test_mismatch_req1();
        test_drop();
        test_alternate();
        test_random();
        test_abort_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
